pe_array_ctrl: RTL and testbench

PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

---
 rtl/mm_pkg.sv | 24 ++
 rtl/pe_skew_line.sv | 33 +++
 rtl/pe_array_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_pe_array_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply mesh and its controller.
//   W        : default operand width
//   T        : default mesh dimension (T x T PEs)
//   PIPE_MUL : extra multiplier pipeline stages inside a PE
//   KMAX     : default maximum inner-dimension length
//   pe_ctrl_state_t : controller FSM state encoding
package mm_pkg;

  localparam int unsigned W        = 8;
  localparam int unsigned T        = 4;
  localparam int unsigned PIPE_MUL = 0;
  localparam int unsigned KMAX     = 256;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StFlush,
    StDrain,
    StWaitV,
    StDone
  } pe_ctrl_state_t;

endpackage

// File: rtl/pe_skew_line.sv
// Fixed-depth shift register carrying one mesh ingress lane {valid, data}.
//   clk    : clock
//   rst    : asynchronous active-high reset, clears every stage
//   i_data : lane input, bit W is the valid flag
//   o_data : lane output, DEPTH cycles later
module pe_skew_line #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W:0]   i_data,
  output logic [W:0]   o_data
);

  logic [W:0] r_stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) begin
        r_stage[s] <= '0;
      end
    end else begin
      r_stage[0] <= i_data;
      for (int s = 1; s < DEPTH; s++) begin
        r_stage[s] <= r_stage[s-1];
      end
    end
  end

  assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/pe_array_ctrl.sv
// Block sequencer for a T x T output-stationary PE mesh.
// Clears the accumulators, streams k_len K-steps into the mesh with a diagonal
// skew, flushes the wavefront, injects a drain pulse and waits for the mesh to
// report every snapshot valid before offering the result grid.
//   clk, rst             : clock, asynchronous active-high reset
//   start, k_len         : begin a block of k_len steps (sampled in idle)
//   k_valid/k_ready      : K-step handshake carrying a_col / b_row
//   a_in_row/a_in_valid  : west ingress, row i skewed by i cycles
//   b_in_col/b_in_valid  : north ingress, column j skewed by j cycles
//   acc_clear_block      : one-cycle accumulator clear broadcast
//   drain_pulse          : one-cycle drain inject at PE[0][0]
//   acc_v_mat            : per-PE snapshot valid grid
//   busy                 : block in progress
//   res_valid/res_ready  : result-grid handshake
//   drain_err            : sticky flag, mesh failed to drain in time
module pe_array_ctrl #(
  parameter int unsigned W        = mm_pkg::W,
  parameter int unsigned T        = mm_pkg::T,
  parameter int unsigned KMAX     = mm_pkg::KMAX,
  parameter int unsigned PE_LAT   = 1 + mm_pkg::PIPE_MUL,
  parameter int unsigned DRAIN_TO = 4 * T * T
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [$clog2(KMAX+1)-1:0] k_len,
  input  logic                      k_valid,
  output logic                      k_ready,
  input  logic [T*W-1:0]            a_col,
  input  logic [T*W-1:0]            b_row,
  output logic [T*W-1:0]            a_in_row,
  output logic [T-1:0]              a_in_valid,
  output logic [T*W-1:0]            b_in_col,
  output logic [T-1:0]              b_in_valid,
  output logic                      acc_clear_block,
  output logic                      drain_pulse,
  input  logic [T*T-1:0]            acc_v_mat,
  output logic                      busy,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      drain_err
);

  import mm_pkg::*;

  localparam int unsigned KW        = $clog2(KMAX + 1);
  // Last step enters lane T-1 after T-1 cycles, crosses T-1 more PEs, then PE_LAT.
  localparam int unsigned FLUSH_CYC = 2 * (T - 1) + PE_LAT + 1;
  localparam int unsigned TMR_MAX   = (FLUSH_CYC > DRAIN_TO) ? FLUSH_CYC : DRAIN_TO;
  localparam int unsigned TMW       = $clog2(TMR_MAX + 1);

  pe_ctrl_state_t r_state;
  logic [KW-1:0]  r_k_len;
  logic [KW-1:0]  r_k_cnt;
  logic [TMW-1:0] r_tmr;
  logic           r_k_ready;
  logic           r_clear;
  logic           r_drain;
  logic           r_busy;
  logic           r_res_valid;
  logic           r_err;

  logic           w_accept;
  logic           w_last_step;
  logic           w_all_v;
  logic [KW-1:0]  w_k_len_sat;

  assign w_accept    = k_valid & r_k_ready;
  assign w_last_step = (r_k_cnt + KW'(1)) == r_k_len;
  assign w_all_v     = &acc_v_mat;
  assign w_k_len_sat = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_k_len     <= '0;
      r_k_cnt     <= '0;
      r_tmr       <= '0;
      r_k_ready   <= 1'b0;
      r_clear     <= 1'b0;
      r_drain     <= 1'b0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Pulses are one cycle wide unless a transition below re-arms them.
      r_clear <= 1'b0;
      r_drain <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_k_len <= w_k_len_sat;
            r_k_cnt <= '0;
            r_err   <= 1'b0;
            r_clear <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= StClear;
          end
        end
        StClear: begin
          if (r_k_len == '0) begin
            r_drain <= 1'b1;
            r_state <= StDrain;
          end else begin
            r_k_ready <= 1'b1;
            r_state   <= StFeed;
          end
        end
        StFeed: begin
          if (w_accept) begin
            r_k_cnt <= r_k_cnt + KW'(1);
            if (w_last_step) begin
              r_k_ready <= 1'b0;
              r_tmr     <= '0;
              r_state   <= StFlush;
            end
          end
        end
        StFlush: begin
          if (r_tmr == TMW'(FLUSH_CYC - 1)) begin
            r_drain <= 1'b1;
            r_state <= StDrain;
          end else begin
            r_tmr <= r_tmr + TMW'(1);
          end
        end
        StDrain: begin
          r_tmr   <= '0;
          r_state <= StWaitV;
        end
        StWaitV: begin
          if (w_all_v) begin
            r_res_valid <= 1'b1;
            r_state     <= StDone;
          end else if (r_tmr == TMW'(DRAIN_TO - 1)) begin
            r_err       <= 1'b1;
            r_res_valid <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_tmr <= r_tmr + TMW'(1);
          end
        end
        StDone: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign k_ready         = r_k_ready;
  assign acc_clear_block = r_clear;
  assign drain_pulse     = r_drain;
  assign busy            = r_busy;
  assign res_valid       = r_res_valid;
  assign drain_err       = r_err;

  // Lane i is i+1 registers deep; bubbles and flush inject zero data, valid 0.
  for (genvar i = 0; i < T; i++) begin : g_lane
    logic [W:0] w_a_in;
    logic [W:0] w_a_out;
    logic [W:0] w_b_in;
    logic [W:0] w_b_out;

    assign w_a_in = {w_accept, w_accept ? a_col[i*W +: W] : {W{1'b0}}};
    assign w_b_in = {w_accept, w_accept ? b_row[i*W +: W] : {W{1'b0}}};

    pe_skew_line #(
      .W    (W),
      .DEPTH(i + 1)
    ) u_a_skew (
      .clk   (clk),
      .rst   (rst),
      .i_data(w_a_in),
      .o_data(w_a_out)
    );

    pe_skew_line #(
      .W    (W),
      .DEPTH(i + 1)
    ) u_b_skew (
      .clk   (clk),
      .rst   (rst),
      .i_data(w_b_in),
      .o_data(w_b_out)
    );

    assign a_in_row[i*W +: W] = w_a_out[W-1:0];
    assign a_in_valid[i]      = w_a_out[W];
    assign b_in_col[i*W +: W] = w_b_out[W-1:0];
    assign b_in_valid[i]      = w_b_out[W];
  end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Randomized bench for pe_array_ctrl. The reference works on absolute edge
// numbers: it records which edges accepted a K step and derives every output
// window (clear, skewed lanes, drain, result handshake) from those numbers.
module tb_pe_array_ctrl;

  localparam int unsigned W        = mm_pkg::W;
  localparam int unsigned T        = mm_pkg::T;
  localparam int unsigned KMAX     = 8;
  localparam int unsigned PE_LAT   = 1;
  localparam int unsigned DRAIN_TO = 4 * T * T;
  localparam int unsigned KLW      = $clog2(KMAX + 1);
  localparam int unsigned DW       = T * W;
  localparam int unsigned VW       = T * T;
  localparam int          FLUSH    = 2 * (T - 1) + PE_LAT + 1;
  localparam int          BIG      = 1 << 28;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [KLW-1:0] k_len;
  logic           k_valid;
  logic           k_ready;
  logic [DW-1:0]  a_col;
  logic [DW-1:0]  b_row;
  logic [DW-1:0]  a_in_row;
  logic [T-1:0]   a_in_valid;
  logic [DW-1:0]  b_in_col;
  logic [T-1:0]   b_in_valid;
  logic           acc_clear_block;
  logic           drain_pulse;
  logic [VW-1:0]  acc_v_mat;
  logic           busy;
  logic           res_valid;
  logic           res_ready;
  logic           drain_err;

  pe_array_ctrl #(
    .W       (W),
    .T       (T),
    .KMAX    (KMAX),
    .PE_LAT  (PE_LAT),
    .DRAIN_TO(DRAIN_TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .k_len          (k_len),
    .k_valid        (k_valid),
    .k_ready        (k_ready),
    .a_col          (a_col),
    .b_row          (b_row),
    .a_in_row       (a_in_row),
    .a_in_valid     (a_in_valid),
    .b_in_col       (b_in_col),
    .b_in_valid     (b_in_valid),
    .acc_clear_block(acc_clear_block),
    .drain_pulse    (drain_pulse),
    .acc_v_mat      (acc_v_mat),
    .busy           (busy),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .drain_err      (drain_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;
  bit exp_err  = 1'b0;

  logic [DW-1:0] a_at [int];
  logic [DW-1:0] b_at [int];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_kready"}, 64'(k_ready), 64'd0);
    check_eq({tag, "_clear"}, 64'(acc_clear_block), 64'd0);
    check_eq({tag, "_drain"}, 64'(drain_pulse), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_resv"}, 64'(res_valid), 64'd0);
    check_eq({tag, "_err"}, 64'(drain_err), 64'd0);
    check_eq({tag, "_lanev"}, 64'({a_in_valid, b_in_valid}), 64'd0);
    check_eq({tag, "_arow"}, 64'(a_in_row), 64'd0);
    check_eq({tag, "_bcol"}, 64'(b_in_col), 64'd0);
  endtask

  function automatic logic [VW-1:0] partial_v();
    logic [VW-1:0] v;
    v = VW'($urandom);
    if (&v) v[0] = 1'b0;
    return v;
  endfunction

  // One block: k_raw requested steps, tmo = mesh never drains,
  // abort_at > 0 = assert reset right after that many accepts.
  task automatic run_block(input int k_raw, input bit tmo, input int abort_at,
                           input bit kv_always);
    int k, s, d, r_dly, q, rr, acc, e, t;
    bit done;
    logic [DW-1:0] ea, eb;
    logic [T-1:0]  eav, ebv;
    k     = (k_raw > int'(KMAX)) ? int'(KMAX) : k_raw;
    a_at.delete();
    b_at.delete();
    s     = edge_n + 1;
    acc   = 0;
    r_dly = $urandom_range(0, 6);
    q     = $urandom_range(0, 3);
    d     = (k == 0) ? s + 1 : BIG;
    rr    = BIG;
    if (d != BIG) rr = tmo ? d + 1 + int'(DRAIN_TO) : d + 2 + r_dly;
    check_eq("err_before_start", 64'(drain_err), 64'(exp_err));
    done = 1'b0;
    while (!done) begin
      e       = edge_n + 1;
      start   = (e == s) ? 1'b1 : ((e > s && acc < k) ? 1'($urandom_range(0, 1)) : 1'b0);
      k_len   = (e == s) ? KLW'(k_raw) : KLW'($urandom);
      k_valid = kv_always ? 1'b1 : ($urandom_range(0, 3) != 0);
      a_col   = DW'($urandom);
      b_row   = DW'($urandom);
      acc_v_mat = (d != BIG && !tmo && e >= d + 2 + r_dly) ? {VW{1'b1}} : partial_v();
      if (e <= rr) res_ready = 1'($urandom_range(0, 1));
      else         res_ready = (e == rr + 1 + q);
      tick();
      t = edge_n;
      if (t >= s + 2 && acc < k && k_valid) begin
        a_at[t] = a_col;
        b_at[t] = b_row;
        acc++;
        if (acc == k) begin
          d  = t + FLUSH;
          rr = tmo ? d + 1 + int'(DRAIN_TO) : d + 2 + r_dly;
        end
      end
      if (t == s) exp_err = 1'b0;
      if (tmo && t == rr) exp_err = 1'b1;

      ea = '0; eb = '0; eav = '0; ebv = '0;
      for (int i = 0; i < int'(T); i++) begin
        if (a_at.exists(t - i)) begin
          eav[i]      = 1'b1;
          ebv[i]      = 1'b1;
          ea[i*W +: W] = a_at[t - i][i*W +: W];
          eb[i*W +: W] = b_at[t - i][i*W +: W];
        end
      end
      check_eq("clear", 64'(acc_clear_block), 64'(t == s));
      check_eq("drain", 64'(drain_pulse), 64'(t == d));
      check_eq("k_ready", 64'(k_ready), 64'(k > 0 && t >= s + 1 && acc < k));
      check_eq("a_valid", 64'(a_in_valid), 64'(eav));
      check_eq("b_valid", 64'(b_in_valid), 64'(ebv));
      check_eq("a_row", 64'(a_in_row), 64'(ea));
      check_eq("b_col", 64'(b_in_col), 64'(eb));
      check_eq("busy", 64'(busy), 64'(t >= s && t <= rr + q));
      check_eq("res_valid", 64'(res_valid), 64'(t >= rr && t <= rr + q));
      check_eq("drain_err", 64'(drain_err), 64'(exp_err));

      if (abort_at > 0 && acc == abort_at) begin
        rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        tick();
        check_all_zero("rst_hold");
        rst     = 1'b0;
        start   = 1'b0;
        exp_err = 1'b0;
        done    = 1'b1;
      end else if (t == rr + 1 + q) begin
        done = 1'b1;
      end
      if (t > s + 400) begin
        check_eq("block_timeout", 64'(t), 64'(s));
        done = 1'b1;
      end
    end
    start     = 1'b0;
    res_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    k_len     = '0;
    k_valid   = 1'b0;
    a_col     = '0;
    b_row     = '0;
    acc_v_mat = '0;
    res_ready = 1'b0;
    @(negedge clk);
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_eq("idle_busy", 64'(busy), 64'd0);

    run_block(4, 1'b0, 0, 1'b1);   // continuous feed
    run_block(0, 1'b0, 0, 1'b0);   // empty block
    run_block(3, 1'b0, 0, 1'b0);   // bubbles
    run_block(12, 1'b0, 0, 1'b0);  // saturates to KMAX
    run_block(5, 1'b1, 0, 1'b0);   // drain timeout
    run_block(2, 1'b0, 0, 1'b0);   // new start clears drain_err
    run_block(6, 1'b0, 2, 1'b1);   // reset during second step
    run_block(4, 1'b0, 0, 1'b0);
    for (int b = 0; b < 20; b++) begin
      run_block($urandom_range(0, 10), ($urandom_range(0, 7) == 0), 0,
                1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
